step_pulse_gen: RTL and testbench

//  Consumes the divided slow clock produced by the clock divider. Converts it into

---
 rtl/step_pulse_gen.sv | 166 ++++++++++++++++
 tb/tb_step_pulse_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns the divided slow clock into single-cycle clock enables
// for the CPU core, with run/halt/single-step control from the front panel and
// a counter of issued enables for the panel display.
module step_pulse_gen #(
  parameter int          SYNC_STAGES     = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter int          STEP_COUNT_W    = 16
) (
  input  logic                    clock_in,
  input  logic                    Rst,
  input  logic                    tick_in,
  input  logic                    Run,
  input  logic                    Halt,
  input  logic                    Step,
  input  logic                    Cnt_clr,
  output logic                    Clk_en,
  output logic                    Halted,
  output logic [1:0]              State,
  output logic [STEP_COUNT_W-1:0] StepCount
);

  typedef enum logic [1:0] {
    ST_HALTED    = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_WAIT = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0]  tick_sync_r;
  logic                    tick_prev_r;
  logic                    tick_rise_s;
  logic [SYNC_STAGES-1:0]  step_sync_r;
  logic [15:0]             deb_cnt_r;
  logic                    deb_level_r;
  logic                    deb_prev_r;
  logic                    step_press_s;
  state_t                  state_r;
  logic                    clk_en_r;
  logic                    halted_r;
  logic [STEP_COUNT_W-1:0] step_cnt_r;

  // The rise detector compares the last sync flop against a delayed copy, so a
  // long high time on tick_in can only produce one pulse.
  assign tick_rise_s  = tick_sync_r[SYNC_STAGES-1] & ~tick_prev_r;
  assign step_press_s = deb_level_r & ~deb_prev_r;

  // Synchronize tick_in and keep the previous synchronized value for edge detection.
  always_ff @(posedge clock_in or posedge Rst) begin
    if (Rst) begin
      tick_sync_r <= '0;
      tick_prev_r <= 1'b0;
    end else begin
      tick_sync_r <= {tick_sync_r[SYNC_STAGES-2:0], tick_in};
      tick_prev_r <= tick_sync_r[SYNC_STAGES-1];
    end
  end

  // Synchronize the raw Step button before it reaches the debouncer.
  always_ff @(posedge clock_in or posedge Rst) begin
    if (Rst) begin
      step_sync_r <= '0;
    end else begin
      step_sync_r <= {step_sync_r[SYNC_STAGES-2:0], Step};
    end
  end

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
  // differing samples; any agreeing sample restarts the count.
  always_ff @(posedge clock_in or posedge Rst) begin
    if (Rst) begin
      deb_cnt_r   <= 16'd0;
      deb_level_r <= 1'b0;
      deb_prev_r  <= 1'b0;
    end else begin
      deb_prev_r <= deb_level_r;
      if (step_sync_r[SYNC_STAGES-1] != deb_level_r) begin
        if (deb_cnt_r == (DEBOUNCE_CYCLES - 16'd1)) begin
          deb_level_r <= step_sync_r[SYNC_STAGES-1];
          deb_cnt_r   <= 16'd0;
        end else begin
          deb_cnt_r <= deb_cnt_r + 16'd1;
        end
      end else begin
        deb_cnt_r <= 16'd0;
      end
    end
  end

  // Run/halt/step FSM with registered enable and halted decode; Halt beats Run
  // beats a step press, and presses outside HALTED are simply dropped.
  always_ff @(posedge clock_in or posedge Rst) begin
    if (Rst) begin
      state_r  <= ST_HALTED;
      clk_en_r <= 1'b0;
      halted_r <= 1'b1;
    end else begin
      case (state_r)
        ST_HALTED: begin
          clk_en_r <= 1'b0;
          if (Halt) begin
            state_r  <= ST_HALTED;
            halted_r <= 1'b1;
          end else if (Run) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end else if (step_press_s) begin
            state_r  <= ST_STEP_WAIT;
            halted_r <= 1'b0;
          end else begin
            state_r  <= ST_HALTED;
            halted_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (Halt) begin
            state_r  <= ST_HALTED;
            clk_en_r <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_RUN;
            clk_en_r <= tick_rise_s;
            halted_r <= 1'b0;
          end
        end
        ST_STEP_WAIT: begin
          if (Halt) begin
            state_r  <= ST_HALTED;
            clk_en_r <= 1'b0;
            halted_r <= 1'b1;
          end else if (tick_rise_s) begin
            state_r  <= ST_HALTED;
            clk_en_r <= 1'b1;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_STEP_WAIT;
            clk_en_r <= 1'b0;
            halted_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_HALTED;
          clk_en_r <= 1'b0;
          halted_r <= 1'b1;
        end
      endcase
    end
  end

  // Count issued enables; a clear request takes precedence over an increment.
  always_ff @(posedge clock_in or posedge Rst) begin
    if (Rst) begin
      step_cnt_r <= '0;
    end else if (Cnt_clr) begin
      step_cnt_r <= '0;
    end else if (clk_en_r) begin
      step_cnt_r <= step_cnt_r + {{(STEP_COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

  assign Clk_en    = clk_en_r;
  assign Halted    = halted_r;
  assign State     = state_r;
  assign StepCount = step_cnt_r;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with a short debounce and a 4-bit counter.
module tb_step_pulse_gen;

  logic       clock_in = 1'b0;
  logic       Rst      = 1'b1;
  logic       tick_in  = 1'b0;
  logic       Run      = 1'b0;
  logic       Halt     = 1'b0;
  logic       Step     = 1'b0;
  logic       Cnt_clr  = 1'b0;
  logic       Clk_en;
  logic       Halted;
  logic [1:0] State;
  logic [3:0] StepCount;

  int n_vec = 0;
  int n_err = 0;

  step_pulse_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16'd8),
    .STEP_COUNT_W   (4)
  ) dut (
    .clock_in (clock_in),
    .Rst      (Rst),
    .tick_in  (tick_in),
    .Run      (Run),
    .Halt     (Halt),
    .Step     (Step),
    .Cnt_clr  (Cnt_clr),
    .Clk_en   (Clk_en),
    .Halted   (Halted),
    .State    (State),
    .StepCount(StepCount)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, returning 1 time unit after the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  // one tick_in pulse sampled at e0..e2; enable expected only after e2
  task automatic send_tick(input logic [31:0] exp_pulse);
    tick_in = 1'b1;
    cyc(1); chk("tick_e0", 32'(Clk_en), 0);
    cyc(1); chk("tick_e1", 32'(Clk_en), 0);
    cyc(1); chk("tick_e2", 32'(Clk_en), exp_pulse);
    tick_in = 1'b0;
    cyc(1); chk("tick_e3", 32'(Clk_en), 0);
    cyc(2);
  endtask

  initial begin
    int presses;
    logic [1:0] prev_state;

    // 1: reset held while tick_in toggles
    for (int i = 0; i < 6; i++) begin
      tick_in = ~tick_in;
      cyc(1);
      chk("rst_clken", 32'(Clk_en), 0);
      chk("rst_halted", 32'(Halted), 1);
      chk("rst_state", 32'(State), 0);
      chk("rst_count", 32'(StepCount), 0);
    end
    tick_in = 1'b0;
    Rst = 1'b0;
    cyc(4);

    // 2: one-cycle Run request, then ten ticks
    Run = 1'b1;
    cyc(1);
    Run = 1'b0;
    chk("run_state", 32'(State), 1);
    chk("run_halted", 32'(Halted), 0);
    for (int i = 0; i < 10; i++) send_tick(1);
    chk("count_10", 32'(StepCount), 10);

    // 3: Halt on the edge that registers tick_rise
    tick_in = 1'b1;
    cyc(2);
    Halt = 1'b1;
    cyc(1);
    chk("halt_clken", 32'(Clk_en), 0);
    chk("halt_state", 32'(State), 0);
    chk("halt_halted", 32'(Halted), 1);
    Halt = 1'b0;
    tick_in = 1'b0;
    cyc(4);
    chk("halt_count", 32'(StepCount), 10);

    // 4: bouncing Step then steady high gives exactly one press
    for (int b = 0; b < 6; b++) begin
      Step = (b % 2 == 0);
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        chk("bounce_state", 32'(State), 0);
      end
    end
    Step = 1'b1;
    presses = 0;
    prev_state = State;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (State == 2'b10 && prev_state != 2'b10) presses++;
      prev_state = State;
    end
    chk("press_count", 32'(presses), 1);
    chk("stepwait_state", 32'(State), 2);
    chk("stepwait_halted", 32'(Halted), 0);
    send_tick(1);
    chk("step_back_halted", 32'(State), 0);
    chk("step_count", 32'(StepCount), 11);
    Step = 1'b0;
    cyc(15);
    chk("release_state", 32'(State), 0);

    // 5: Run coinciding with a press wins; a press in RUN is dropped
    Step = 1'b1;
    cyc(10);
    chk("pre_press_state", 32'(State), 0);
    Run = 1'b1;
    cyc(1);
    Run = 1'b0;
    chk("run_over_press", 32'(State), 1);
    Step = 1'b0;
    cyc(12);
    Step = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      chk("press_in_run", 32'(State), 1);
    end
    Halt = 1'b1;
    cyc(1);
    Halt = 1'b0;
    chk("halt2_state", 32'(State), 0);
    cyc(5);
    chk("press_not_queued", 32'(State), 0);
    Run = 1'b1;
    Halt = 1'b1;
    cyc(1);
    chk("halt_over_run", 32'(State), 0);
    Run = 1'b0;
    Halt = 1'b0;
    Step = 1'b0;

    // 6: counter clear, wrap 15->0, clear beats increment
    Run = 1'b1;
    cyc(1);
    Run = 1'b0;
    Cnt_clr = 1'b1;
    cyc(1);
    Cnt_clr = 1'b0;
    chk("clr_count", 32'(StepCount), 0);
    for (int i = 0; i < 16; i++) begin
      send_tick(1);
      chk("wrap_count", 32'(StepCount), (i + 1) % 16);
    end
    for (int i = 0; i < 3; i++) send_tick(1);
    chk("count_3", 32'(StepCount), 3);
    tick_in = 1'b1;
    cyc(3);
    chk("clr_pulse", 32'(Clk_en), 1);
    Cnt_clr = 1'b1;
    cyc(1);
    Cnt_clr = 1'b0;
    chk("clr_wins", 32'(StepCount), 0);
    tick_in = 1'b0;
    cyc(3);

    // Rst mid-pulse, then tick_in already high after release
    send_tick(1);
    tick_in = 1'b1;
    cyc(3);
    chk("pre_rst_pulse", 32'(Clk_en), 1);
    #1 Rst = 1'b1;
    #1;
    chk("arst_clken", 32'(Clk_en), 0);
    chk("arst_state", 32'(State), 0);
    chk("arst_halted", 32'(Halted), 1);
    chk("arst_count", 32'(StepCount), 0);
    cyc(1);
    Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("post_rst_clken", 32'(Clk_en), 0);
      chk("post_rst_state", 32'(State), 0);
    end
    tick_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
